alu_cmd_sequencer: RTL

Upstream command feeder for the serial 8-bit alu. Buffers complete commands (op_code, operand A, operand B) in a small FIFO and drives the alu's BEGIN/inbus load protocol one command at a time. Captures the alu's outbus result once END is asserted, one byte or two bytes depending on the operation, and returns it on a valid/ready result port. A watchdog aborts any transaction whose END never arrives.

---
 rtl/alu_cmd_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// Command feeder for the serial 8-bit alu: queues commands, runs the BEGIN/inbus
// load handshake, and returns the one- or two-byte result with a watchdog abort.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [1:0]  res_op,
    output logic        res_timeout,
    output logic        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_OP  = 3'd1;
    localparam logic [2:0] S_LOAD_A   = 3'd2;
    localparam logic [2:0] S_WAIT_END = 3'd3;
    localparam logic [2:0] S_CAP_HI   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [17:0]      fifo_mem_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s, pop_s, full_s;

    logic [2:0]       state_r, state_s;
    logic [1:0]       op_r, op_s;
    logic [7:0]       a_r, a_s, b_r, b_s;
    logic [WD_W-1:0]  wd_cnt_r, wd_cnt_s;
    logic [15:0]      res_data_r, res_data_s;
    logic             res_timeout_r, res_timeout_s;

    logic             alu_begin_r, alu_begin_s;
    logic [1:0]       alu_op_code_r, alu_op_code_s;
    logic [7:0]       alu_inbus_r, alu_inbus_s;
    logic             res_valid_r, res_valid_s;
    logic             busy_r, busy_s;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full_s    = (count_r == FULL_CNT);
    assign cmd_ready = ~reset & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;

    // Next-state logic: sequencing, watchdog and result capture.
    always_comb begin
        state_s       = state_r;
        op_s          = op_r;
        a_s           = a_r;
        b_s           = b_r;
        wd_cnt_s      = wd_cnt_r;
        res_data_s    = res_data_r;
        res_timeout_s = res_timeout_r;
        pop_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s              = 1'b1;
                    {op_s, a_s, b_s}   = fifo_mem_r[rd_ptr_r];
                    state_s            = S_LOAD_OP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD_OP: state_s = S_LOAD_A;
            S_LOAD_A: begin
                wd_cnt_s = {WD_W{1'b0}};
                state_s  = S_WAIT_END;
            end
            S_WAIT_END: begin
                // END beats the watchdog when both land on the same cycle.
                if (alu_end) begin
                    res_data_s[7:0] = alu_outbus;
                    res_timeout_s   = 1'b0;
                    wd_cnt_s        = {WD_W{1'b0}};
                    if (op_r[1]) begin
                        state_s = S_CAP_HI;
                    end else begin
                        res_data_s[15:8] = 8'h00;
                        state_s          = S_DONE;
                    end
                end else if (wd_cnt_r == WD_LAST) begin
                    res_data_s    = 16'hFFFF;
                    res_timeout_s = 1'b1;
                    wd_cnt_s      = {WD_W{1'b0}};
                    state_s       = S_DONE;
                end else begin
                    wd_cnt_s = wd_cnt_r + WD_W'(1);
                end
            end
            S_CAP_HI: begin
                res_data_s[15:8] = alu_outbus;
                state_s          = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    res_timeout_s = 1'b0;
                    state_s       = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the alu-facing pins come straight off flops.
    always_comb begin
        alu_begin_s   = (state_s == S_LOAD_OP) || (state_s == S_LOAD_A);
        alu_op_code_s = (state_s == S_IDLE) ? 2'b00 : op_s;
        res_valid_s   = (state_s == S_DONE);
        busy_s        = (state_s != S_IDLE);
        case (state_s)
            S_IDLE:    alu_inbus_s = 8'h00;
            S_LOAD_OP: alu_inbus_s = 8'h00;
            S_LOAD_A:  alu_inbus_s = a_s;
            default:   alu_inbus_s = b_s;
        endcase
    end

    // Control, pointer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            state_r       <= S_IDLE;
            op_r          <= 2'b00;
            a_r           <= 8'h00;
            b_r           <= 8'h00;
            wd_cnt_r      <= {WD_W{1'b0}};
            res_data_r    <= 16'h0000;
            res_timeout_r <= 1'b0;
            alu_begin_r   <= 1'b0;
            alu_op_code_r <= 2'b00;
            alu_inbus_r   <= 8'h00;
            res_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            state_r       <= state_s;
            op_r          <= op_s;
            a_r           <= a_s;
            b_r           <= b_s;
            wd_cnt_r      <= wd_cnt_s;
            res_data_r    <= res_data_s;
            res_timeout_r <= res_timeout_s;
            alu_begin_r   <= alu_begin_s;
            alu_op_code_r <= alu_op_code_s;
            alu_inbus_r   <= alu_inbus_s;
            res_valid_r   <= res_valid_s;
            busy_r        <= busy_s;
        end
    end

    // Command storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_a, cmd_b};
    end

    assign alu_begin   = alu_begin_r;
    assign alu_op_code = alu_op_code_r;
    assign alu_inbus   = alu_inbus_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_op      = op_r;
    assign res_timeout = res_timeout_r;
    assign busy        = busy_r;
endmodule
